// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry elastic pipeline buffer with stall, flush and
// a saturating counter of entries discarded by flush. Control and data
// payloads travel together through a circular buffer.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       flush_drops
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointer advance with wrap at DEPTH-1, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(DEPTH - 1)) begin
            nxt = PTR_W'(0);
        end else begin
            nxt = p + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Saturating 16-bit accumulate of a discarded-entry count.
    function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                              input logic [CNT_W-1:0] add);
        logic [16:0] sum;
        logic [15:0] res;
        sum = {1'b0, acc} + 17'(add);
        if (sum[16]) begin
            res = 16'hFFFF;
        end else begin
            res = sum[15:0];
        end
        return res;
    endfunction

    // Storage is deliberately unreset: validity comes only from count_q.
    logic [CTRL_W-1:0] ctrl_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [15:0]      drops_q,  drops_d;

    logic push_s;
    logic pop_s;
    logic out_valid_s;
    logic in_ready_s;

    // Handshake qualification; in_ready depends only on state and stall/flush.
    always_comb begin
        out_valid_s = (count_q != CNT_W'(0));
        in_ready_s  = rst && !stall && !flush && (count_q < CNT_W'(DEPTH));
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready && !stall && !flush;
    end

    // Next-state for pointers, occupancy and the flush-drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drops_d  = drops_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
            drops_d  = sat_add16(drops_q, count_q);
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            drops_q  <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drops_q  <= drops_d;
        end
    end

    // Payload write into the slot at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ctrl_mem_q[wr_ptr_q] <= in_ctrl;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Present the head entry, or an all-zero bubble when empty.
    always_comb begin
        in_ready    = in_ready_s;
        out_valid   = out_valid_s;
        count       = count_q;
        flush_drops = drops_q;
        if (out_valid_s) begin
            out_ctrl = ctrl_mem_q[rd_ptr_q];
            out_data = data_mem_q[rd_ptr_q];
        end else begin
            out_ctrl = {CTRL_W{1'b0}};
            out_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf: a DEPTH=2 instance (a_*) and a
// DEPTH=4 instance (b_*) share clock and reset.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_stall, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_ctrl, a_out_ctrl, a_drops;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_stall, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_ctrl, b_out_ctrl, b_drops;
    logic [63:0] b_in_data, b_out_data;
    logic [2:0]  b_count;

    int checks = 0;
    int failures = 0;

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .count(a_count), .flush_drops(a_drops)
    );

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .count(b_count), .flush_drops(b_drops)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_stall = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_ctrl = 16'h0000; a_in_data = 64'h0;
        b_stall = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_ctrl = 16'h0000; b_in_data = 64'h0;

        // Reset held
        step();
        check_val("rst_count", 64'(a_count), 64'd0);
        check_val("rst_out_valid", 64'(a_out_valid), 64'd0);
        check_val("rst_in_ready", 64'(a_in_ready), 64'd0);
        check_val("rst_out_data", a_out_data, 64'h0);
        check_val("rst_drops", 64'(b_drops), 64'd0);

        // Release reset together with the first offer
        rst = 1'b1;
        #1;
        check_val("rel_in_ready", 64'(a_in_ready), 64'd1);
        a_in_valid = 1'b1; a_in_ctrl = 16'h0001; a_in_data = 64'hA; a_out_ready = 1'b1;
        check_val("first_out_valid_same_cycle", 64'(a_out_valid), 64'd0);
        step();
        a_in_valid = 1'b0;
        check_val("first_out_valid", 64'(a_out_valid), 64'd1);
        check_val("first_ctrl", 64'(a_out_ctrl), 64'h0001);
        check_val("first_data", a_out_data, 64'hA);
        check_val("first_count1", 64'(a_count), 64'd1);
        step();
        check_val("first_count0", 64'(a_count), 64'd0);
        check_val("first_bubble_ctrl", 64'(a_out_ctrl), 64'h0);
        check_val("first_bubble_data", a_out_data, 64'h0);

        // Streaming: 10 back-to-back pushes with constant out_ready
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            a_in_ctrl  = 16'h0100 + 16'(i);
            a_in_data  = 64'hD000 + 64'(i);
            step();
            check_val("stream_valid", 64'(a_out_valid), 64'd1);
            check_val("stream_ctrl", 64'(a_out_ctrl), 64'h0100 + 64'(i));
            check_val("stream_data", a_out_data, 64'hD000 + 64'(i));
            check_val("stream_count", 64'(a_count), 64'd1);
        end
        a_in_valid = 1'b0;
        step();
        check_val("stream_drained", 64'(a_count), 64'd0);

        // Backpressure: fill, offer a third entry, then drain
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 16'h0200; a_in_data = 64'hB200;
        step();
        a_in_ctrl = 16'h0201; a_in_data = 64'hB201;
        step();
        check_val("bp_full_count", 64'(a_count), 64'd2);
        check_val("bp_full_in_ready", 64'(a_in_ready), 64'd0);
        a_in_ctrl = 16'h0202; a_in_data = 64'hB202;
        step();
        check_val("bp_hold_count", 64'(a_count), 64'd2);
        check_val("bp_hold_head", 64'(a_out_ctrl), 64'h0200);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check_val("bp_no_comb_ready", 64'(a_in_ready), 64'd0);
        step();
        check_val("bp_drain1_ctrl", 64'(a_out_ctrl), 64'h0201);
        check_val("bp_drain1_data", a_out_data, 64'hB201);
        check_val("bp_ready_back", 64'(a_in_ready), 64'd1);
        step();
        check_val("bp_drain_empty", 64'(a_count), 64'd0);

        // Stall with one entry buffered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 16'h0300; a_in_data = 64'hC300;
        step();
        a_stall = 1'b1; a_out_ready = 1'b1; a_in_ctrl = 16'h0301; a_in_data = 64'hC301;
        #1;
        check_val("stall_in_ready", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_count", 64'(a_count), 64'd1);
            check_val("stall_ctrl", 64'(a_out_ctrl), 64'h0300);
            check_val("stall_data", a_out_data, 64'hC300);
        end
        a_stall = 1'b0;
        step();
        check_val("resume_count", 64'(a_count), 64'd1);
        check_val("resume_ctrl", 64'(a_out_ctrl), 64'h0301);
        a_in_valid = 1'b0;
        step();
        check_val("resume_empty", 64'(a_count), 64'd0);

        // Flush while empty leaves flush_drops alone
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        check_val("flush_empty_drops", 64'(a_drops), 64'd0);

        // DEPTH=4: fill, then flush with stall and an offered input
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_ctrl = 16'h0400 + 16'(i);
            b_in_data = 64'hE400 + 64'(i);
            step();
        end
        check_val("b_full_count", 64'(b_count), 64'd4);
        check_val("b_full_in_ready", 64'(b_in_ready), 64'd0);
        check_val("b_full_head", 64'(b_out_ctrl), 64'h0400);
        b_stall = 1'b1; b_flush = 1'b1; b_in_ctrl = 16'h04FF; b_in_data = 64'hE4FF;
        step();
        check_val("b_flush_count", 64'(b_count), 64'd0);
        check_val("b_flush_valid", 64'(b_out_valid), 64'd0);
        check_val("b_flush_ctrl", 64'(b_out_ctrl), 64'h0);
        check_val("b_flush_data", b_out_data, 64'h0);
        check_val("b_flush_drops", 64'(b_drops), 64'd4);
        b_stall = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
        step();
        check_val("b_flush_input_dropped", 64'(b_count), 64'd0);

        // Three entries, then asynchronous reset mid-cycle
        b_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_ctrl = 16'h0500 + 16'(i);
            b_in_data = 64'hF500 + 64'(i);
            step();
        end
        b_in_valid = 1'b0;
        check_val("b_three_count", 64'(b_count), 64'd3);
        check_val("b_three_head", 64'(b_out_ctrl), 64'h0500);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_count", 64'(b_count), 64'd0);
        check_val("async_rst_valid", 64'(b_out_valid), 64'd0);
        check_val("async_rst_data", b_out_data, 64'h0);
        check_val("async_rst_drops", 64'(b_drops), 64'd0);
        step();
        rst = 1'b1;
        b_in_valid = 1'b1; b_in_ctrl = 16'h0600; b_in_data = 64'hF600;
        step();
        b_in_valid = 1'b0;
        check_val("post_rst_count", 64'(b_count), 64'd1);
        check_val("post_rst_head", 64'(b_out_ctrl), 64'h0600);
        check_val("post_rst_data", b_out_data, 64'hF600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64: width of the data payload per entry.
REQ-002 Parameter CTRL_W, default 16: width of the control payload per entry.
REQ-003 Parameter DEPTH, default 2, legal range 2..8 (not limited to powers of two): number of buffered entries.
REQ-004 Parameter CNT_W, default $clog2(DEPTH+1), derived, not overridden: width of the occupancy count.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (stage in reset while rst==0).
REQ-007 stall  input  1  freeze: no push, no pop, all state held.
REQ-008 flush  input  1  discard all buffered entries and any same-cycle input.
REQ-009 in_valid  input  1  upstream offers an entry.
REQ-010 in_ready  output  1  stage accepts an entry this cycle.
REQ-011 in_ctrl  input  CTRL_W  control payload of offered entry.
REQ-012 in_data  input  DATA_W  data payload of offered entry.
REQ-013 out_valid  output  1  head entry presented downstream.
REQ-014 out_ready  input  1  downstream consumes head entry this cycle.
REQ-015 out_ctrl  output  CTRL_W  head control payload; all-zero (bubble) when out_valid==0.
REQ-016 out_data  output  DATA_W  head data payload; all-zero when out_valid==0.
REQ-017 count  output  CNT_W  number of valid buffered entries, 0..DEPTH.
REQ-018 flush_drops  output  16  saturating count of valid entries discarded by flush.

Function
REQ-019 Storage: circular buffer of DEPTH entries, write pointer, read pointer, count; pointers wrap from DEPTH-1 to 0.
REQ-020 in_ready = !stall && !flush && (count < DEPTH); no combinational path from out_ready to in_ready.
REQ-021 Push occurs when in_valid && in_ready; entry written at write pointer, write pointer advances.
REQ-022 out_valid = (count != 0); out_ctrl/out_data driven from the read-pointer entry, else zero.
REQ-023 Pop occurs when out_valid && out_ready && !stall && !flush; read pointer advances.
REQ-024 Latency: entry pushed in cycle N is visible at outputs in cycle N+1 at earliest.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance; sustains one transfer per cycle.
REQ-026 Full (count==DEPTH): in_ready==0; pop that cycle frees a slot usable the following cycle.
REQ-027 Empty (count==0): no pop; a push makes count 1 next cycle.
REQ-028 Order: entries leave in exact acceptance order; no entry duplicated or lost except by flush.
REQ-029 stall==1: pointers, count, storage, flush_drops hold; outputs keep presenting current head.
REQ-030 flush==1 (priority over stall): next cycle count=0, pointers=0, out_valid=0; same-cycle input not accepted.
REQ-031 On flush, flush_drops += count (value before flush), saturating at 16'hFFFF.
REQ-032 flush with count==0: flush_drops unchanged.
REQ-033 Storage contents never reset-dependent for correctness; outputs zeroed by REQ-022 whenever empty.

Reset
REQ-034 rst==0 asynchronously forces count=0, pointers=0, flush_drops=0, hence out_valid=0, out_ctrl=0, out_data=0, in_ready=0 while held.
REQ-035 Reset mid-operation discards all buffered entries; no partial entry emerges after release.
REQ-036 First push accepted on the first rising edge with rst==1, in_valid==1, stall==0, flush==0.

Verification
REQ-037 Reset release, DEPTH=2: push ctrl 16'h0001/data 64'hA, out_ready=1 -> out_valid=1 next cycle with 0x0001/0xA, count=1, then 0.
REQ-038 Streaming: 10 back-to-back pushes, out_ready=1 constant -> 10 outputs in order, one per cycle, count stays 1.
REQ-039 Backpressure: out_ready=0, push until in_ready=0 -> count=DEPTH; raise out_ready -> entries drain in order, in_ready returns next cycle.
REQ-040 Stall: stall=1 for 3 cycles with in_valid=1, out_ready=1, count=1 -> no push/pop, outputs/count unchanged; resume correct.
REQ-041 Flush while full (DEPTH=4) with stall=1 and in_valid=1 -> next cycle count=0, out_valid=0, outputs zero, flush_drops=4; input dropped.
REQ-042 Async reset asserted mid-cycle with count=3 -> count=0 and out_valid=0 immediately, before next clock edge.
